// File: rtl/chev_map_pkg.sv
// chev_map_pkg: shared types and fixed-point helpers for the chaotic-map blocks.
package chev_map_pkg;
  typedef enum logic [1:0] {IDLE, STEP, EMIT} state_t;
  typedef logic signed [63:0] wide_t;
  function automatic wide_t one(int w);
    return 64'sd1 <<< (w - 2);
  endfunction
  function automatic wide_t sat(wide_t v, int w);
    wide_t lim;
    lim = one(w);
    return v > lim ? lim : (v < -lim ? -lim : v);
  endfunction
  function automatic int clamp_deg(int d, int dmax);
    return d < 2 ? 2 : (d > dmax ? dmax : d);
  endfunction
endpackage

// File: rtl/chev_fix_mac.sv
// chev_fix_mac: combinational sat(2*x*t_cur - t_prev) in signed Q2.(W-2).
module chev_fix_mac import chev_map_pkg::*; #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] t_cur,
  input  logic [W-1:0] t_prev,
  output logic [W-1:0] y
);
  localparam int FRAC = W - 2;
  localparam logic signed [2*W-1:0] RND = {{(2*W-1){1'b0}}, 1'b1} << (FRAC - 2);
  logic signed [2*W-1:0] prod, sh;
  logic signed [W+1:0] dbl, diff;
  wide_t s;
  always_comb begin
    prod = (2*W)'($signed(x)) * (2*W)'($signed(t_cur));
    // shifting by FRAC-1 instead of FRAC folds in the factor of two
    sh   = (prod + RND) >>> (FRAC - 1);
    dbl  = sh[W+1:0];
    diff = dbl - (W+2)'($signed(t_prev));
    s    = sat(wide_t'(diff), W);
    y    = s[W-1:0];
  end
endmodule

// File: rtl/chev_map_iter.sv
// chev_map_iter: iterates x <- T_deg(x) via the Chebyshev recurrence, streaming each iterate.
module chev_map_iter import chev_map_pkg::*; #(
  parameter int W       = 32,
  parameter int DEG_MAX = 8,
  parameter int ITER_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_x,
  input  logic [$clog2(DEG_MAX+1)-1:0] in_deg,
  input  logic [ITER_W-1:0]            in_iters,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 out_x,
  output logic                         out_last,
  output logic                         busy
);
  localparam int DW = $clog2(DEG_MAX + 1);
  localparam logic [W-1:0] ONE_W = W'(one(W));
  state_t state;
  logic [W-1:0] x_reg, t_prev, t_cur, mac_y, sx_w;
  logic [DW-1:0] k, deg_reg;
  logic [ITER_W-1:0] iter_left;
  wide_t sx;
  chev_fix_mac #(.W(W)) u_mac (.x(x_reg), .t_cur(t_cur), .t_prev(t_prev), .y(mac_y));
  assign sx        = sat(wide_t'($signed(in_x)), W);
  assign sx_w      = sx[W-1:0];
  assign in_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign out_valid = state == EMIT;
  assign out_x     = t_cur;
  assign out_last  = state == EMIT && iter_left == ITER_W'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_reg     <= '0;
      t_prev    <= '0;
      t_cur     <= '0;
      k         <= '0;
      deg_reg   <= '0;
      iter_left <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x_reg     <= sx_w;
          t_prev    <= ONE_W;
          t_cur     <= sx_w;
          k         <= DW'(1);
          deg_reg   <= DW'(clamp_deg(int'(in_deg), DEG_MAX));
          iter_left <= in_iters == '0 ? ITER_W'(1) : in_iters;
          state     <= STEP;
        end
        STEP: begin
          t_cur  <= mac_y;
          t_prev <= t_cur;
          k      <= k + DW'(1);
          if (k + DW'(1) == deg_reg) state <= EMIT;
        end
        EMIT: if (out_ready) begin
          if (iter_left > ITER_W'(1)) begin
            // t_cur already holds T_1 of the new seed, so only t_prev restarts
            x_reg     <= t_cur;
            t_prev    <= ONE_W;
            k         <= DW'(1);
            iter_left <= iter_left - ITER_W'(1);
            state     <= STEP;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
